load_store_unit: RTL

//  Data-memory stage downstream of the ALU. Takes the ALU's effective address, rs2 data, opcode and funct3.

---
 rtl/load_store_unit.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// RV32I data-memory stage: runs byte/half/word loads and stores as a req/ack bus
// transaction, stalls the core until completion, and reports alignment, funct3 and bus errors.
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        stall,
    output logic        done,
    output logic [31:0] load_data,
    output logic        err_misaligned,
    output logic        err_illegal,
    output logic        err_bus,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);
    localparam logic [6:0] OpLoad  = 7'b0000011;
    localparam logic [6:0] OpStore = 7'b0100011;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q;
    logic [2:0]      funct3_q;
    logic [1:0]      off_q;
    logic            store_q;

    logic        is_load, is_store, accept, illegal, misaligned, bus_timeout;
    logic [3:0]  strb;
    logic [31:0] wdata, rd_shift, rd_ext;

    always_comb begin
        is_load  = (opcode == OpLoad);
        is_store = (opcode == OpStore);
        accept   = (state_q == StIdle) && start && (is_load || is_store);

        if (is_load) begin
            illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
        end else begin
            illegal = funct3[2] || (funct3 == 3'b011);
        end

        case (funct3[1:0])
            2'b01:   misaligned = addr[0];
            2'b10:   misaligned = (addr[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase

        bus_timeout = (state_q == StBusy) && !mem_ack && (cnt_q == CntLast);
    end

    // Store lanes: narrow data is replicated across the word so any byte enable finds it.
    always_comb begin
        case (funct3[1:0])
            2'b00: begin
                strb  = 4'b0001 << addr[1:0];
                wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                strb  = 4'b0011 << addr[1:0];
                wdata = {2{store_data[15:0]}};
            end
            default: begin
                strb  = 4'b1111;
                wdata = store_data;
            end
        endcase
    end

    always_comb begin
        rd_shift = mem_rdata >> {off_q, 3'b000};
        case (funct3_q)
            3'b000:  rd_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'b001:  rd_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'b100:  rd_ext = {24'h0, rd_shift[7:0]};
            3'b101:  rd_ext = {16'h0, rd_shift[15:0]};
            default: rd_ext = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = (illegal || misaligned) ? StDone : StBusy;
                end
            end
            StBusy: begin
                if (mem_ack || bus_timeout) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        stall = accept || (state_q == StBusy);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q          <= '0;
            funct3_q       <= 3'b000;
            off_q          <= 2'b00;
            store_q        <= 1'b0;
            done           <= 1'b0;
            load_data      <= 32'h0;
            err_misaligned <= 1'b0;
            err_illegal    <= 1'b0;
            err_bus        <= 1'b0;
            mem_req        <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= 32'h0;
            mem_wdata      <= 32'h0;
            mem_wstrb      <= 4'b0000;
        end else begin
            mem_req <= (state_d == StBusy);
            done    <= (state_d == StDone);
            if (accept) begin
                funct3_q       <= funct3;
                off_q          <= addr[1:0];
                store_q        <= is_store;
                cnt_q          <= '0;
                err_illegal    <= illegal;
                err_misaligned <= !illegal && misaligned;
                err_bus        <= 1'b0;
                if (illegal || misaligned) begin
                    load_data <= 32'h0;
                end else begin
                    mem_we    <= is_store;
                    mem_addr  <= {addr[31:2], 2'b00};
                    mem_wstrb <= is_store ? strb : 4'b0000;
                    mem_wdata <= is_store ? wdata : 32'h0;
                end
            end else if (state_q == StBusy) begin
                if (mem_ack) begin
                    load_data <= store_q ? 32'h0 : rd_ext;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                    if (bus_timeout) begin
                        err_bus   <= 1'b1;
                        load_data <= 32'h0;
                    end
                end
            end
        end
    end

endmodule
